// File: rtl/magia_mesh_ctrl_pkg.sv
// Shared types and default strapping constants for the MAGIA mesh boot sequencer.
package magia_mesh_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENABLE,
    ST_BOOT,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } boot_seq_state_e;

  localparam logic [31:0] BOOT_BASE_DEF   = 32'hCC00_0000;
  localparam logic [31:0] BOOT_STRIDE_DEF = 32'h0001_0000;
  localparam logic [31:0] HARTID_BASE_DEF = 32'd0;

  function automatic logic [31:0] boot_addr(input int unsigned idx,
                                            input logic [31:0] base   = BOOT_BASE_DEF,
                                            input logic [31:0] stride = BOOT_STRIDE_DEF);
    return base + 32'(idx) * stride;
  endfunction

endpackage

// File: rtl/magia_wu_pulse.sv
// Rising-edge detector on a wake-up request, qualified by an enable; one-cycle pulse out.
module magia_wu_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req_i,
  output logic pulse_o
);

  logic r_req_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req_q <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      r_req_q <= req_i;
      pulse_o <= en_i & req_i & ~r_req_q;
    end
  end

endmodule

// File: rtl/magia_mesh_boot_sequencer.sv
// Boot and run-control sequencer for N MAGIA tiles: staggered fetch enable,
// wake-up delivery, sleep-based completion and a watchdog.
module magia_mesh_boot_sequencer
  import magia_mesh_ctrl_pkg::*;
#(
  parameter int unsigned N_TILES      = 4,
  parameter int unsigned ENABLE_HOLD  = 4,
  parameter int unsigned STAGGER      = 8,
  parameter int unsigned SLEEP_STABLE = 16,
  parameter logic [31:0] BOOT_BASE    = BOOT_BASE_DEF,
  parameter logic [31:0] BOOT_STRIDE  = BOOT_STRIDE_DEF,
  parameter logic [31:0] HARTID_BASE  = HARTID_BASE_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [N_TILES-1:0]    tile_mask_i,
  input  logic [31:0]           timeout_cycles_i,
  input  logic [N_TILES-1:0]    core_sleep_i,
  input  logic [N_TILES-1:0]    wu_req_i,
  output logic [N_TILES-1:0]    tile_enable_o,
  output logic [N_TILES-1:0]    fetch_enable_o,
  output logic [N_TILES-1:0]    wu_wfe_o,
  output logic [32*N_TILES-1:0] boot_addr_o,
  output logic [32*N_TILES-1:0] mhartid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam int unsigned STG_W  = (STAGGER > 0) ? $clog2(STAGGER + 1) : 1;
  localparam int unsigned SLP_W  = $clog2(SLEEP_STABLE + 1);
  localparam int unsigned HOLD_W = $clog2(ENABLE_HOLD + 1);

  boot_seq_state_e    r_state;
  logic [N_TILES-1:0] r_mask;
  logic [HOLD_W-1:0]  r_hold;
  logic [STG_W-1:0]   r_stg;
  logic [SLP_W-1:0]   r_stable;
  logic [31:0]        r_wdog;

  logic [N_TILES-1:0] w_pending;
  logic [N_TILES-1:0] w_next_oh;
  logic [N_TILES-1:0] w_boot_set;
  logic [N_TILES-1:0] w_wu_en;
  logic               w_active;
  logic               w_all_sleep;
  logic               w_done_hit;
  logic               w_tmo_hit;

  // Lowest-index masked tile that has not been fetch-enabled yet.
  assign w_pending   = r_mask & ~fetch_enable_o;
  assign w_next_oh   = w_pending & (~w_pending + N_TILES'(1));
  assign w_boot_set  = (STAGGER == 0) ? w_pending : w_next_oh;

  assign w_active    = (r_state == ST_BOOT) || (r_state == ST_RUN);
  assign w_all_sleep = (core_sleep_i & r_mask) == r_mask;
  assign w_done_hit  = (r_state == ST_RUN) && w_all_sleep &&
                       (r_stable == SLP_W'(SLEEP_STABLE - 1));
  assign w_tmo_hit   = w_active && (timeout_cycles_i != 32'd0) &&
                       (r_wdog == timeout_cycles_i - 32'd1);

  // A pulse landing on the edge into DONE/TIMEOUT is suppressed.
  assign w_wu_en = fetch_enable_o & {N_TILES{w_active && !w_done_hit && !w_tmo_hit}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_mask         <= '0;
      r_hold         <= '0;
      r_stg          <= '0;
      r_stable       <= '0;
      r_wdog         <= '0;
      tile_enable_o  <= '0;
      fetch_enable_o <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      if (w_active && (r_wdog != '1)) r_wdog <= r_wdog + 32'd1;
      case (r_state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start_i && (tile_mask_i != '0)) begin
            r_state        <= ST_ENABLE;
            r_mask         <= tile_mask_i;
            tile_enable_o  <= tile_mask_i;
            fetch_enable_o <= '0;
            r_hold         <= '0;
            busy_o         <= 1'b1;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
          end
        end
        ST_ENABLE: begin
          if (r_hold == HOLD_W'(ENABLE_HOLD - 1)) begin
            r_state        <= ST_BOOT;
            fetch_enable_o <= w_boot_set;
            r_stg          <= '0;
            r_wdog         <= '0;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        ST_BOOT: begin
          if (w_tmo_hit) begin
            r_state        <= ST_TIMEOUT;
            fetch_enable_o <= '0;
            busy_o         <= 1'b0;
            timeout_o      <= 1'b1;
          end else if (w_pending == '0) begin
            r_state  <= ST_RUN;
            r_stable <= '0;
          end else if (r_stg == STG_W'(STAGGER - 1)) begin
            fetch_enable_o <= fetch_enable_o | w_next_oh;
            r_stg          <= '0;
          end else begin
            r_stg <= r_stg + STG_W'(1);
          end
        end
        ST_RUN: begin
          if (w_done_hit) begin
            r_state        <= ST_DONE;
            fetch_enable_o <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b1;
          end else if (w_tmo_hit) begin
            r_state        <= ST_TIMEOUT;
            fetch_enable_o <= '0;
            busy_o         <= 1'b0;
            timeout_o      <= 1'b1;
          end else if (w_all_sleep) begin
            r_stable <= r_stable + SLP_W'(1);
          end else begin
            r_stable <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_TILES; gi++) begin : g_tile
    assign boot_addr_o[32*gi +: 32] = boot_addr(gi, BOOT_BASE, BOOT_STRIDE);
    assign mhartid_o[32*gi +: 32]   = HARTID_BASE + 32'(gi);

    magia_wu_pulse u_wu_pulse (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (w_wu_en[gi]),
      .req_i   (wu_req_i[gi]),
      .pulse_o (wu_wfe_o[gi])
    );
  end

endmodule

// File: doc/magia_mesh_boot_sequencer.md
Name: magia_mesh_boot_sequencer

Overview:
Parametrised boot and run-control sequencer for N MAGIA tiles. It generalises the single-tile fixed control strapping (tile_enable, fetch_enable, boot_addr, mhartid, wu_wfe) to a masked multi-tile sequence:
- power-up hold, then staggered fetch-enable per tile;
- per-tile wake-up event delivery;
- end-of-test detection from core_sleep, plus a watchdog.

It sits between the testbench or mesh top-level control and the tile control inputs.

Parameters:
N_TILES, 4, number of controlled tiles (1..64)
ENABLE_HOLD, 4, cycles between tile_enable rise and first fetch_enable (>=1)
STAGGER, 8, cycles between successive fetch_enable rises; 0 = all masked tiles in one cycle
SLEEP_STABLE, 16, consecutive cycles all masked tiles must sleep to declare done (>=1)
BOOT_BASE, 32'hCC00_0000, boot address of tile 0
BOOT_STRIDE, 32'h0001_0000, boot address increment per tile index
HARTID_BASE, 0, mhartid of tile 0

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start pulse; sampled only in IDLE/DONE/TIMEOUT
tile_mask_i  in  N_TILES  tiles participating in the run; sampled with start_i
timeout_cycles_i  in  32  watchdog limit counted from BOOT entry; 0 disables it
core_sleep_i  in  N_TILES  per-tile core_sleep
wu_req_i  in  N_TILES  per-tile wake-up request, level or pulse
tile_enable_o  out  N_TILES  per-tile tile_enable
fetch_enable_o  out  N_TILES  per-tile fetch_enable
wu_wfe_o  out  N_TILES  per-tile wake-up pulse
boot_addr_o  out  32*N_TILES  slice i = BOOT_BASE + i*BOOT_STRIDE (constant)
mhartid_o  out  32*N_TILES  slice i = HARTID_BASE + i (constant)
busy_o  out  1  high in ENABLE/BOOT/RUN
done_o  out  1  sticky completion flag
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset, including mid-operation: at the next edge all registered outputs go to 0, state = IDLE, all counters cleared. boot_addr_o and mhartid_o are constants, unaffected by reset. All other outputs are registered.
- States: IDLE, ENABLE, BOOT, RUN, DONE, TIMEOUT.
- IDLE -> ENABLE: start_i=1 with tile_mask_i != 0.
  - Mask latched.
  - tile_enable_o = mask from the next cycle.
  - start_i with a zero mask is ignored.
- ENABLE: counts ENABLE_HOLD cycles, then enters BOOT.
- BOOT: fetch_enable bit set for masked tiles in ascending index order.
  - First bit rises in the first BOOT cycle; each next masked bit rises STAGGER cycles later.
  - Unmasked indices are skipped with no delay.
  - STAGGER=0: all masked bits rise in the first BOOT cycle.
  - After the last bit is set -> RUN next cycle.
- Watchdog: 32-bit counter, starts at 0 on BOOT entry, increments every BOOT/RUN cycle.
  - counter == timeout_cycles_i-1 with timeout_cycles_i != 0 -> TIMEOUT.
  - Saturates; no wrap.
- RUN completion: stable counter increments while (core_sleep_i & mask) == mask, else clears to 0.
  - Counter reaching SLEEP_STABLE -> DONE.
  - core_sleep_i is ignored before RUN.
- Wake-up: wu_wfe_o[i] is high exactly one cycle, the cycle after a rising edge of wu_req_i[i], and only if fetch_enable_o[i] is already high. Applies in BOOT and RUN.
  - A request on a not-yet-fetched or unmasked tile is dropped.
  - A held-high request produces one pulse only.
- DONE and TIMEOUT:
  - fetch_enable_o cleared, tile_enable_o held, wu_wfe_o forced 0.
  - done_o (DONE) or timeout_o (TIMEOUT) set sticky.
  - busy_o = 0.
- Restart: start_i with a nonzero mask -> ENABLE. done_o and timeout_o cleared the same edge; tile_enable_o reloaded with the new mask.
- Simultaneous events:
  - done and timeout conditions in the same cycle -> DONE wins.
  - start_i while busy -> ignored.

Decomposition:
- Shared package magia_mesh_ctrl_pkg holds:
  - state enum boot_seq_state_e;
  - default constants for BOOT_BASE, BOOT_STRIDE, HARTID_BASE;
  - function boot_addr(idx).
- Sub-module magia_wu_pulse: per-tile rising-edge detector with an enable qualifier. Instantiated N_TILES times via generate.
- Stagger counter width: $clog2(STAGGER+1).
- Next-tile selection: priority encoder over mask & ~fetch_enable.

Test Plan:
- Reset: rst_i high 3 cycles mid-RUN -> all outputs 0 next edge, busy_o=0; boot_addr_o slice 2 = 32'hCC02_0000, mhartid_o slice 3 = 3.
- N_TILES=4, start at edge t, mask 4'b1111:
  - tile_enable_o=4'b1111 at t+1;
  - fetch_enable bit0 at t+5, bit1 at t+13, bit2 at t+21, bit3 at t+29;
  - busy_o high from t+1.
- Mask 4'b1010:
  - fetch_enable[1] at t+5, fetch_enable[3] at t+13;
  - bits 0 and 2 stay 0 throughout;
  - sleep on tiles 0 and 2 ignored.
- Completion: all masked core_sleep high in RUN; one low cycle after 10 highs restarts the count -> done_o rises after 16 uninterrupted highs; fetch_enable_o=0 in the same cycle.
- Watchdog: timeout_cycles_i=100, core_sleep held 0 -> timeout_o set exactly 100 cycles after BOOT entry, fetch_enable_o cleared; a second start_i clears timeout_o.
- Wake-up: wu_req_i[2] held high 5 cycles after fetch_enable[2] -> single 1-cycle wu_wfe_o[2]; wu_req_i[3] before fetch_enable[3] -> no pulse.
